ysyx_22050039_exec_ctrl: RTL and testbench

Multi-cycle sequencer for the NPC datapath. It drives instruction fetch, gates the decoder's PC and GPR write enables into a single write-back cycle, and stalls on load/store memory handshakes and on the iterative divider (Divw). It retires instructions, counts them, and halts on ebreak, invalid instruction or handshake timeout. It sits between IFU/IDU/EXU/LSU and owns all state-advancing strobes.

---
 rtl/ysyx_22050039_ctrl_pkg.sv | 21 ++
 rtl/ysyx_22050039_timeout_cnt.sv | 35 +++
 rtl/ysyx_22050039_exec_ctrl.sv | 155 +++++++++++++++
 tb/tb_ysyx_22050039_exec_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050039_ctrl_pkg.sv
// Shared types and defaults for the NPC execution sequencer.
package ysyx_22050039_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_DIVW   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } ctrl_state_t;

  localparam int unsigned TIMEOUT_DEF = 255;

  // States that wait on an external handshake and are guarded by the timeout.
  function automatic logic is_wait_state(input ctrl_state_t s);
    return (s == S_FETCH) || (s == S_MEM) || (s == S_DIVW);
  endfunction

endpackage

// File: rtl/ysyx_22050039_timeout_cnt.sv
// 8-bit handshake watchdog; expired marks the cycle in which the count of
// unanswered cycles reaches TIMEOUT.
module ysyx_22050039_timeout_cnt
  import ysyx_22050039_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] r_cnt;
  logic [7:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 8'd1;
  assign expired   = en & (w_cnt_inc == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (clr) begin
      r_cnt <= 8'd0;
    end else if (en) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/ysyx_22050039_exec_ctrl.sv
// Multi-cycle NPC sequencer: fetch, decode dispatch, memory/divider stalls,
// single-cycle write-back, retire counting and sticky halt.
module ysyx_22050039_exec_ctrl
  import ysyx_22050039_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            if_req,
  input  logic            if_ack,
  output logic            inst_en,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_div,
  input  logic            dec_ebreak,
  input  logic            dec_invalid,
  input  logic            dec_pc_wen,
  input  logic            dec_reg_wen,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            div_start,
  input  logic            div_done,
  output logic            pc_wen,
  output logic            pc_sel,
  output logic            reg_wen,
  output logic [XLEN-1:0] instret,
  output logic            halted,
  output logic            err,
  output logic [2:0]      state
);

  ctrl_state_t     r_state;
  ctrl_state_t     w_next;
  logic            w_halt_err;
  logic            w_wait;
  logic            w_ack;
  logic            w_expired;
  logic            r_if_req;
  logic            r_mem_req;
  logic            r_div_start;
  logic            r_pc_wen;
  logic            r_halted;
  logic            r_err;
  logic [XLEN-1:0] r_instret;

  assign w_wait = is_wait_state(r_state);
  assign w_ack  = ((r_state == S_FETCH) & if_ack) |
                  ((r_state == S_MEM)   & mem_ack) |
                  ((r_state == S_DIVW)  & div_done);

  ysyx_22050039_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (~w_wait),
    .en      (w_wait & ~w_ack),
    .expired (w_expired)
  );

  always_comb begin
    w_next     = r_state;
    w_halt_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
        else     w_next = S_IDLE;
      end
      S_FETCH: begin
        if (if_ack) begin
          w_next = S_DECODE;
        end else if (w_expired) begin
          w_next     = S_HALT;
          w_halt_err = 1'b1;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_invalid || (dec_load && dec_store)) begin
          w_next     = S_HALT;
          w_halt_err = 1'b1;
        end else if (dec_ebreak) begin
          w_next = S_HALT;
        end else if (dec_div) begin
          w_next = S_DIVW;
        end else if (dec_load || dec_store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      // An ack arriving in the expiry cycle still completes the handshake.
      S_MEM, S_DIVW: begin
        if (w_ack) begin
          w_next = S_WB;
        end else if (w_expired) begin
          w_next     = S_HALT;
          w_halt_err = 1'b1;
        end else begin
          w_next = r_state;
        end
      end
      S_WB: begin
        if (run) w_next = S_FETCH;
        else     w_next = S_IDLE;
      end
      S_HALT:  w_next = S_HALT;
      default: begin
        w_next     = S_HALT;
        w_halt_err = 1'b1;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_if_req    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_div_start <= 1'b0;
      r_pc_wen    <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
      r_instret   <= '0;
    end else begin
      r_state     <= w_next;
      r_if_req    <= (w_next == S_FETCH);
      r_mem_req   <= (w_next == S_MEM);
      r_div_start <= (w_next == S_DIVW) && (r_state != S_DIVW);
      r_pc_wen    <= (w_next == S_WB);
      r_halted    <= (w_next == S_HALT);
      r_err       <= r_err | w_halt_err;
      if (r_state == S_WB) r_instret <= r_instret + XLEN'(1);
      else                 r_instret <= r_instret;
    end
  end

  assign if_req    = r_if_req;
  assign inst_en   = r_if_req & if_ack;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_req & dec_store;
  assign div_start = r_div_start;
  assign pc_wen    = r_pc_wen;
  assign pc_sel    = r_pc_wen & dec_pc_wen;
  assign reg_wen   = r_pc_wen & dec_reg_wen;
  assign instret   = r_instret;
  assign halted    = r_halted;
  assign err       = r_err;
  assign state     = r_state;

endmodule

// File: tb/tb_ysyx_22050039_exec_ctrl.sv
// Randomized instruction-level bench for the NPC sequencer: per instruction the
// expected duration, handshake shape, write-back and halt outcome are computed.
module tb_ysyx_22050039_exec_ctrl;

  localparam int TO = 8;
  localparam int XL = 64;
  localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_DIV = 3;
  localparam int C_EBREAK = 4, C_INVALID = 5, C_LDST = 6;

  logic clk = 1'b0;
  logic rst, run, if_ack, mem_ack, div_done;
  logic dec_load, dec_store, dec_div, dec_ebreak, dec_invalid, dec_pc_wen, dec_reg_wen;
  logic if_req, inst_en, mem_req, mem_we, div_start, pc_wen, pc_sel, reg_wen, halted, err;
  logic [XL-1:0] instret;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail = 0;
  longint unsigned exp_instret = 0;

  ysyx_22050039_exec_ctrl #(.XLEN(XL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .if_req(if_req), .if_ack(if_ack), .inst_en(inst_en),
    .dec_load(dec_load), .dec_store(dec_store), .dec_div(dec_div), .dec_ebreak(dec_ebreak),
    .dec_invalid(dec_invalid), .dec_pc_wen(dec_pc_wen), .dec_reg_wen(dec_reg_wen),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .div_start(div_start),
    .div_done(div_done), .pc_wen(pc_wen), .pc_sel(pc_sel), .reg_wen(reg_wen),
    .instret(instret), .halted(halted), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input int cls, input logic pcw, input logic rw);
    dec_load    = (cls == C_LOAD) || (cls == C_LDST);
    dec_store   = (cls == C_STORE) || (cls == C_LDST);
    dec_div     = (cls == C_DIV);
    dec_ebreak  = (cls == C_EBREAK);
    dec_invalid = (cls == C_INVALID);
    dec_pc_wen  = pcw;
    dec_reg_wen = rw;
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; if_ack = 1'b0; mem_ack = 1'b0; div_done = 1'b0;
    set_dec(C_ALU, 1'b0, 1'b0);
    repeat (2) step();
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_strobes", 64'({if_req, mem_req, div_start, pc_wen, reg_wen, pc_sel, mem_we, inst_en}), 64'd0);
    check_eq("rst_flags", 64'({halted, err}), 64'd0);
    check_eq("rst_instret", instret, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_instret = 0;
    step();
    run = 1'b1;
    step();
    check_eq("idle_to_fetch", 64'({state, if_req}), 64'({3'd1, 1'b1}));
  endtask

  // Execute one instruction: df/dm/dd are the wait cycles before each ack.
  task automatic run_inst(input int cls, input int df, input int dm, input int dd,
                          input logic pcw, input logic rw, input logic go_idle, output logic wb);
    int f_seen, m_seen, d_seen, dur, mreq_cyc, dstart, exp_dur, exp_mreq, exp_dstart;
    logic done, bad, exp_halt, exp_err, wb_pcsel, wb_regwen;
    f_seen = 0; m_seen = 0; d_seen = -1; dur = 0; mreq_cyc = 0; dstart = 0;
    done = 1'b0; bad = 1'b0; wb = 1'b0; wb_pcsel = 1'b0; wb_regwen = 1'b0;
    exp_halt = 1'b0; exp_err = 1'b0; exp_mreq = 0; exp_dstart = 0;
    set_dec(cls, pcw, rw);

    if (df >= TO) begin
      exp_halt = 1'b1; exp_err = 1'b1; exp_dur = TO;
    end else begin
      exp_dur = df + 2;
      if (cls == C_INVALID || cls == C_LDST) begin
        exp_halt = 1'b1; exp_err = 1'b1;
      end else if (cls == C_EBREAK) begin
        exp_halt = 1'b1;
      end else if (cls == C_DIV) begin
        exp_dstart = 1;
        if (dd >= TO) begin exp_halt = 1'b1; exp_err = 1'b1; exp_dur += TO; end
        else exp_dur += dd + 2;
      end else if (cls == C_LOAD || cls == C_STORE) begin
        exp_mreq = (dm >= TO) ? TO : dm + 1;
        if (dm >= TO) begin exp_halt = 1'b1; exp_err = 1'b1; exp_dur += TO; end
        else exp_dur += dm + 2;
      end else begin
        exp_dur += 1;
      end
    end

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (halted) begin
        done = 1'b1;
      end else begin
        if (div_start) d_seen = 0;
        run      = (pc_wen && go_idle) ? 1'b0 : 1'b1;
        if_ack   = if_req && (f_seen == df);
        mem_ack  = mem_req && (m_seen == dm);
        div_done = (d_seen == dd);
        #1;
        if (inst_en !== (if_req && if_ack)) bad = 1'b1;
        if ((int'(if_req) + int'(mem_req) + int'(div_start)) > 1) bad = 1'b1;
        if (!pc_wen && (reg_wen || pc_sel)) bad = 1'b1;
        if (mem_we !== (mem_req && dec_store)) bad = 1'b1;
        if (if_req) f_seen++;
        if (mem_req) begin m_seen++; mreq_cyc++; end
        if (div_start) dstart++;
        if (d_seen >= 0) d_seen++;
        if (pc_wen) begin
          wb = 1'b1; wb_pcsel = pc_sel; wb_regwen = reg_wen; done = 1'b1;
        end
        dur++;
        @(posedge clk);
        #1;
      end
    end
    if_ack = 1'b0; mem_ack = 1'b0; div_done = 1'b0;

    if (!exp_halt) exp_instret++;
    check_eq("bound", 64'(done), 64'd1);
    check_eq("duration", 64'(dur), 64'(exp_dur));
    check_eq("halted", 64'(halted), 64'(exp_halt));
    check_eq("retired", 64'(wb), 64'(!exp_halt));
    check_eq("mem_req_cycles", 64'(mreq_cyc), 64'(exp_mreq));
    check_eq("div_start_pulses", 64'(dstart), 64'(exp_dstart));
    check_eq("strobe_rules", 64'(bad), 64'd0);
    check_eq("instret", instret, exp_instret);
    if (exp_halt) check_eq("err", 64'(err), 64'(exp_err));
    else check_eq("wb_sel_wen", 64'({wb_pcsel, wb_regwen}), 64'({pcw, rw}));
  endtask

  task automatic episode(input int n, input int final_kind);
    logic wb, go_idle, leaked;
    int cls, df, dm, dd;
    do_reset();
    for (int i = 0; i < n; i++) begin
      cls = $urandom_range(0, 3);
      df = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 1);
      dm = $urandom_range(0, TO - 1);
      dd = $urandom_range(0, TO - 1);
      go_idle = ($urandom_range(0, 4) == 0);
      run_inst(cls, df, dm, dd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), go_idle, wb);
      if (wb && go_idle) begin
        check_eq("wb_to_idle", 64'({state, if_req}), 64'({3'd0, 1'b0}));
        run = 1'b0;
        repeat (2) step();
        check_eq("idle_hold", 64'({state, if_req}), 64'({3'd0, 1'b0}));
        run = 1'b1;
        step();
        check_eq("idle_resume", 64'(state), 64'd1);
      end
    end
    case (final_kind)
      0: run_inst(C_EBREAK, 0, 0, 0, 1'b0, 1'b0, 1'b0, wb);
      1: run_inst(C_INVALID, 1, 0, 0, 1'b0, 1'b1, 1'b0, wb);
      2: run_inst(C_LDST, 0, 0, 0, 1'b0, 1'b1, 1'b0, wb);
      3: run_inst(C_ALU, TO + 3, 0, 0, 1'b0, 1'b1, 1'b0, wb);
      4: run_inst(C_LOAD, 0, TO + 5, 0, 1'b0, 1'b1, 1'b0, wb);
      default: run_inst(C_DIV, 0, 0, TO + 5, 1'b0, 1'b1, 1'b0, wb);
    endcase
    leaked = 1'b0;
    repeat (5) begin
      run = 1'b1; if_ack = 1'b1; mem_ack = 1'b1; div_done = 1'b1;
      #1;
      if (if_req || mem_req || div_start || pc_wen || !halted) leaked = 1'b1;
      step();
    end
    check_eq("halt_absorb", 64'(leaked), 64'd0);
    check_eq("halt_instret", instret, exp_instret);
  endtask

  initial begin
    logic wb;
    for (int e = 0; e < 6; e++) episode(4 + e * 2, e);

    // Boundary: ack exactly on the TIMEOUT-th waiting cycle still retires.
    do_reset();
    run_inst(C_LOAD, 0, TO - 1, 0, 1'b0, 1'b1, 1'b0, wb);
    run_inst(C_DIV, TO - 1, 0, TO - 1, 1'b1, 1'b0, 1'b0, wb);
    run_inst(C_STORE, 0, 0, 0, 1'b0, 1'b0, 1'b0, wb);
    run_inst(C_ALU, 0, 0, 0, 1'b1, 1'b1, 1'b0, wb);

    // Reset dropped in the middle of a divide.
    set_dec(C_DIV, 1'b0, 1'b1);
    if_ack = 1'b1;
    step();
    if_ack = 1'b0;
    step();
    check_eq("divw_enter", 64'({state, div_start}), 64'({3'd4, 1'b1}));
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    check_eq("midrst_state", 64'(state), 64'd0);
    check_eq("midrst_strobes", 64'({if_req, mem_req, div_start, pc_wen, reg_wen, pc_sel, mem_we, halted, err}), 64'd0);
    check_eq("midrst_instret", instret, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    step();
    check_eq("post_rst_fetch", 64'({state, if_req}), 64'({3'd1, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
